// File: rtl/lcd_char_writer_if.sv
// Core-to-LCD-writer byte channel plus the HD44780 4-bit write bus driven by the writer.
// Handshake: a byte moves on every clock edge where iData_Ready and oReadyForData are both 1;
// iData only needs to be valid on that cycle, and oReadyForData drops on the following cycle.
interface lcd_char_writer_if;
  logic [7:0] iData;
  logic       iData_Ready;
  logic       oReadyForData;
  logic       oLCD_Enabled;
  logic       oLCD_RegisterSelect;
  logic       oLCD_StrataFlashControl;
  logic       oLCD_ReadWrite;
  logic [3:0] oLCD_Data;

  modport master (
    output iData, iData_Ready,
    input  oReadyForData, oLCD_Enabled, oLCD_RegisterSelect,
           oLCD_StrataFlashControl, oLCD_ReadWrite, oLCD_Data
  );

  modport slave (
    input  iData, iData_Ready,
    output oReadyForData, oLCD_Enabled, oLCD_RegisterSelect,
           oLCD_StrataFlashControl, oLCD_ReadWrite, oLCD_Data
  );
endinterface

// File: rtl/lcd_char_writer.sv
// HD44780 4-bit writer: runs power-on init and configuration itself, then writes each
// accepted byte as two E-strobed nibbles with RS=1.
module lcd_char_writer #(
  parameter int unsigned P_POWERON_CYC = 750000,
  parameter int unsigned P_INIT1_CYC   = 205000,
  parameter int unsigned P_INIT2_CYC   = 5000,
  parameter int unsigned P_CMD_CYC     = 2000,
  parameter int unsigned P_CLEAR_CYC   = 82000,
  parameter int unsigned P_GAP_CYC     = 50,
  parameter int unsigned P_SETUP_CYC   = 2,
  parameter int unsigned P_PULSE_CYC   = 12,
  parameter int unsigned P_CNT_W       = 20
) (
  input  logic              Clock,
  input  logic              Reset,
  lcd_char_writer_if.slave  bus,
  output logic [4:0]        oDebugState
);

  typedef enum logic [2:0] {POWERON_WAIT, INIT_NIB, CFG_BYTE, IDLE, DATA_BYTE} state_t;
  typedef enum logic [1:0] {PH_SETUP, PH_PULSE, PH_HOLD, PH_WAIT} phase_t;
  typedef logic [P_CNT_W-1:0] cnt_t;

  // Count-down loads are N-1 so each wait lasts exactly N cycles.
  localparam cnt_t C_POWERON = cnt_t'(P_POWERON_CYC - 1);
  localparam cnt_t C_INIT1   = cnt_t'(P_INIT1_CYC - 1);
  localparam cnt_t C_INIT2   = cnt_t'(P_INIT2_CYC - 1);
  localparam cnt_t C_CMD     = cnt_t'(P_CMD_CYC - 1);
  localparam cnt_t C_CLEAR   = cnt_t'(P_CLEAR_CYC - 1);
  localparam cnt_t C_GAP     = cnt_t'(P_GAP_CYC - 1);
  localparam cnt_t C_SETUP   = cnt_t'(P_SETUP_CYC - 1);
  localparam cnt_t C_PULSE   = cnt_t'(P_PULSE_CYC - 1);

  state_t     state;
  phase_t     phase;
  cnt_t       cnt;
  logic [1:0] k;
  logic       hiNib;
  logic [7:0] dataByte;

  cnt_t       holdWait;
  logic [7:0] curCfg;
  logic [7:0] nextCfg;
  logic [3:0] nextInitNib;

  function automatic logic [7:0] cfgByte(input logic [1:0] idx);
    case (idx)
      2'd0:    return 8'h28;
      2'd1:    return 8'h06;
      2'd2:    return 8'h0C;
      default: return 8'h01;
    endcase
  endfunction

  function automatic cnt_t initWait(input logic [1:0] idx);
    case (idx)
      2'd0:    return C_INIT1;
      2'd1:    return C_INIT2;
      default: return C_CMD;
    endcase
  endfunction

  // k wraps 3->0, so nextCfg leaving the last init nibble is the first config byte.
  always_comb begin
    curCfg      = cfgByte(k);
    nextCfg     = cfgByte(2'(k + 2'd1));
    nextInitNib = (k == 2'd2) ? 4'h2 : 4'h3;
    holdWait    = C_CMD;
    case (state)
      INIT_NIB: holdWait = initWait(k);
      CFG_BYTE: begin
        if (hiNib)            holdWait = C_GAP;
        else if (k == 2'd3)   holdWait = C_CLEAR;
      end
      DATA_BYTE: if (hiNib)   holdWait = C_GAP;
      default: ;
    endcase
  end

  assign oDebugState = {state, phase};

  always_ff @(posedge Clock) begin
    bus.oLCD_ReadWrite          <= 1'b0;
    bus.oLCD_StrataFlashControl <= 1'b1;
    if (Reset) begin
      state                   <= POWERON_WAIT;
      phase                   <= PH_WAIT;
      cnt                     <= '0;
      k                       <= 2'd0;
      hiNib                   <= 1'b0;
      dataByte                <= 8'h00;
      bus.oLCD_Enabled        <= 1'b0;
      bus.oLCD_RegisterSelect <= 1'b0;
      bus.oLCD_Data           <= 4'h0;
      bus.oReadyForData       <= 1'b0;
    end else begin
      case (state)
        POWERON_WAIT: begin
          if (cnt == C_POWERON) begin
            state         <= INIT_NIB;
            k             <= 2'd0;
            phase         <= PH_SETUP;
            cnt           <= C_SETUP;
            bus.oLCD_Data <= 4'h3;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        IDLE: begin
          if (bus.iData_Ready && bus.oReadyForData) begin
            dataByte                <= bus.iData;
            bus.oReadyForData       <= 1'b0;
            state                   <= DATA_BYTE;
            hiNib                   <= 1'b1;
            bus.oLCD_RegisterSelect <= 1'b1;
            phase                   <= PH_SETUP;
            cnt                     <= C_SETUP;
            bus.oLCD_Data           <= bus.iData[7:4];
          end
        end
        default: begin
          // Shared nibble sub-sequence: setup, E pulse, one hold cycle, then the post-write wait.
          case (phase)
            PH_SETUP: begin
              if (cnt == '0) begin
                bus.oLCD_Enabled <= 1'b1;
                phase            <= PH_PULSE;
                cnt              <= C_PULSE;
              end else begin
                cnt <= cnt - 1'b1;
              end
            end
            PH_PULSE: begin
              if (cnt == '0) begin
                bus.oLCD_Enabled <= 1'b0;
                phase            <= PH_HOLD;
              end else begin
                cnt <= cnt - 1'b1;
              end
            end
            PH_HOLD: begin
              bus.oLCD_Data <= 4'h0;
              phase         <= PH_WAIT;
              cnt           <= holdWait;
            end
            default: begin
              if (cnt != '0) begin
                cnt <= cnt - 1'b1;
              end else begin
                case (state)
                  INIT_NIB: begin
                    phase <= PH_SETUP;
                    cnt   <= C_SETUP;
                    k     <= 2'(k + 2'd1);
                    if (k == 2'd3) begin
                      state         <= CFG_BYTE;
                      hiNib         <= 1'b1;
                      bus.oLCD_Data <= nextCfg[7:4];
                    end else begin
                      bus.oLCD_Data <= nextInitNib;
                    end
                  end
                  CFG_BYTE: begin
                    if (hiNib) begin
                      hiNib         <= 1'b0;
                      phase         <= PH_SETUP;
                      cnt           <= C_SETUP;
                      bus.oLCD_Data <= curCfg[3:0];
                    end else if (k == 2'd3) begin
                      state             <= IDLE;
                      bus.oReadyForData <= 1'b1;
                    end else begin
                      k             <= 2'(k + 2'd1);
                      hiNib         <= 1'b1;
                      phase         <= PH_SETUP;
                      cnt           <= C_SETUP;
                      bus.oLCD_Data <= nextCfg[7:4];
                    end
                  end
                  DATA_BYTE: begin
                    if (hiNib) begin
                      hiNib         <= 1'b0;
                      phase         <= PH_SETUP;
                      cnt           <= C_SETUP;
                      bus.oLCD_Data <= dataByte[3:0];
                    end else begin
                      state             <= IDLE;
                      bus.oReadyForData <= 1'b1;
                    end
                  end
                  default: state <= POWERON_WAIT;
                endcase
              end
            end
          endcase
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_char_writer.sv
// Directed bench for lcd_char_writer with shortened timing; a negedge monitor records every
// E falling edge ({RS, nibble}), E-high widths and bus invariant violations.
module tb_lcd_char_writer;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] dbgState;

  lcd_char_writer_if bus();

  lcd_char_writer #(
    .P_POWERON_CYC(20), .P_INIT1_CYC(10), .P_INIT2_CYC(5), .P_CMD_CYC(4),
    .P_CLEAR_CYC(8), .P_GAP_CYC(3), .P_SETUP_CYC(2), .P_PULSE_CYC(4), .P_CNT_W(20)
  ) dut (
    .Clock       (clk),
    .Reset       (rst),
    .bus         (bus),
    .oDebugState (dbgState)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int         checks = 0;
  int         errors = 0;
  logic [4:0] exp_q[$];
  logic [4:0] obs_q[$];
  int         pw_q[$];
  int         fall_q[$];
  int         cyc = 0;
  int         invErr = 0;
  int         highLen = 0;
  logic       prevE = 1'b0;
  logic       prevRs = 1'b0;
  logic [3:0] prevData = 4'h0;

  logic [4:0] initExp [12];
  initial initExp = '{5'h03, 5'h03, 5'h03, 5'h02, 5'h02, 5'h08,
                      5'h00, 5'h06, 5'h00, 5'h0C, 5'h00, 5'h01};

  // ---------------- bus monitor ----------------
  always @(negedge clk) begin
    cyc++;
    if (bus.oLCD_ReadWrite !== 1'b0 || bus.oLCD_StrataFlashControl !== 1'b1) invErr++;
    if (bus.oLCD_Enabled === 1'b1) begin
      if (!rst && (bus.oLCD_RegisterSelect !== prevRs || bus.oLCD_Data !== prevData)) invErr++;
      highLen++;
    end else if (prevE) begin
      if (!rst && (bus.oLCD_RegisterSelect !== prevRs || bus.oLCD_Data !== prevData)) invErr++;
      obs_q.push_back({prevRs, prevData});
      pw_q.push_back(highLen);
      fall_q.push_back(cyc);
      highLen = 0;
    end
    prevE    = (bus.oLCD_Enabled === 1'b1);
    prevRs   = bus.oLCD_RegisterSelect;
    prevData = bus.oLCD_Data;
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_queues();
    exp_q.delete();
    obs_q.delete();
    pw_q.delete();
    fall_q.delete();
  endtask

  task automatic wait_ready(input int budget, output int readyCyc, output bit timedOut);
    timedOut = 1'b1;
    readyCyc = -1;
    for (int i = 0; i < budget; i++) begin
      step();
      if (bus.oReadyForData === 1'b1) begin
        readyCyc = cyc;
        timedOut = 1'b0;
        break;
      end
    end
  endtask

  // Runs from reset release until ready, optionally poking iData_Ready while busy.
  task automatic collect_init(input bit poke, output int readyCyc, output bit timedOut);
    timedOut = 1'b1;
    readyCyc = -1;
    for (int i = 0; i < 1000; i++) begin
      step();
      if (bus.oReadyForData === 1'b1) begin
        bus.iData_Ready = 1'b0;
        readyCyc = cyc;
        timedOut = 1'b0;
        break;
      end
      bus.iData       = 8'hEE;
      bus.iData_Ready = poke && (i % 7 == 3);
    end
    bus.iData_Ready = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, output int acceptCyc);
    bus.iData       = b;
    bus.iData_Ready = 1'b1;
    acceptCyc       = cyc;
    step();
    bus.iData_Ready = 1'b0;
    bus.iData       = 8'h00;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int rc; bit to; logic [4:0] got; logic [4:0] e; int w; int lastFall;
    rst = 1'b1; bus.iData = 8'h00; bus.iData_Ready = 1'b0;
    repeat (5) step();
    checks++; if (bus.oLCD_Enabled !== 1'b0) begin errors++; $display("FAIL reset_E got %b exp 0", bus.oLCD_Enabled); end
    checks++; if (bus.oLCD_RegisterSelect !== 1'b0) begin errors++; $display("FAIL reset_RS got %b exp 0", bus.oLCD_RegisterSelect); end
    checks++; if (bus.oLCD_Data !== 4'h0) begin errors++; $display("FAIL reset_Data got %h exp 0", bus.oLCD_Data); end
    checks++; if (bus.oReadyForData !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", bus.oReadyForData); end
    checks++; if (dbgState[4:2] !== 3'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", dbgState[4:2]); end
    clear_queues();
    rst = 1'b0;
    collect_init(1'b0, rc, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL init_timeout got timeout exp ready"); end
    lastFall = (fall_q.size() >= 12) ? fall_q[11] : -100;
    checks++; if (rc - lastFall !== 9) begin errors++; $display("FAIL init_ready_gap got %0d exp 9", rc - lastFall); end
    while (pw_q.size() > 0) begin
      w = pw_q.pop_front();
      checks++; if (w !== 4) begin errors++; $display("FAIL init_pulse_width got %0d exp 4", w); end
    end
    for (int i = 0; i < 12; i++) exp_q.push_back(initExp[i]);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      got = (obs_q.size() > 0) ? obs_q.pop_front() : 5'bx;
      checks++; if (got !== e) begin errors++; $display("FAIL init_nibble got %h exp %h", got, e); end
    end
    checks++; if (obs_q.size() !== 0) begin errors++; $display("FAIL init_extra got %0d exp 0", obs_q.size()); end
  endtask

  task automatic test_single_byte();
    int t; int rc; bit to; logic [4:0] got; logic [4:0] e; int w; int f0; int f1;
    clear_queues();
    checks++; if (bus.oReadyForData !== 1'b1) begin errors++; $display("FAIL single_pre_ready got %b exp 1", bus.oReadyForData); end
    send_byte(8'h41, t);
    checks++; if (bus.oReadyForData !== 1'b0) begin errors++; $display("FAIL single_ready_drop got %b exp 0", bus.oReadyForData); end
    wait_ready(100, rc, to);
    checks++; if (to !== 1'b0 || rc - t !== 22) begin errors++; $display("FAIL single_ready_return got %0d exp 22", rc - t); end
    f0 = (fall_q.size() >= 2) ? fall_q[0] - t : -1;
    f1 = (fall_q.size() >= 2) ? fall_q[1] - t : -1;
    checks++; if (f0 !== 7) begin errors++; $display("FAIL single_hi_fall got %0d exp 7", f0); end
    checks++; if (f1 !== 17) begin errors++; $display("FAIL single_lo_fall got %0d exp 17", f1); end
    while (pw_q.size() > 0) begin
      w = pw_q.pop_front();
      checks++; if (w !== 4) begin errors++; $display("FAIL single_pulse_width got %0d exp 4", w); end
    end
    exp_q.push_back(5'h14); exp_q.push_back(5'h11);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      got = (obs_q.size() > 0) ? obs_q.pop_front() : 5'bx;
      checks++; if (got !== e) begin errors++; $display("FAIL single_nibble got %h exp %h", got, e); end
    end
    checks++; if (obs_q.size() !== 0) begin errors++; $display("FAIL single_extra got %0d exp 0", obs_q.size()); end
  endtask

  task automatic test_back_to_back();
    int t; int rc1; int rc2; bit to; logic [4:0] got; logic [4:0] e;
    clear_queues();
    bus.iData = 8'h48; bus.iData_Ready = 1'b1; t = cyc;
    step();
    bus.iData = 8'h69;
    checks++; if (bus.oReadyForData !== 1'b0) begin errors++; $display("FAIL b2b_first_drop got %b exp 0", bus.oReadyForData); end
    wait_ready(100, rc1, to);
    checks++; if (to !== 1'b0 || rc1 - t !== 22) begin errors++; $display("FAIL b2b_window1 got %0d exp 22", rc1 - t); end
    step();
    bus.iData_Ready = 1'b0; bus.iData = 8'h00;
    checks++; if (bus.oReadyForData !== 1'b0) begin errors++; $display("FAIL b2b_second_drop got %b exp 0", bus.oReadyForData); end
    wait_ready(100, rc2, to);
    checks++; if (to !== 1'b0 || rc2 - rc1 !== 22) begin errors++; $display("FAIL b2b_window2 got %0d exp 22", rc2 - rc1); end
    repeat (5) step();
    exp_q.push_back(5'h14); exp_q.push_back(5'h18); exp_q.push_back(5'h16); exp_q.push_back(5'h19);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      got = (obs_q.size() > 0) ? obs_q.pop_front() : 5'bx;
      checks++; if (got !== e) begin errors++; $display("FAIL b2b_nibble got %h exp %h", got, e); end
    end
    checks++; if (obs_q.size() !== 0) begin errors++; $display("FAIL b2b_extra got %0d exp 0", obs_q.size()); end
  endtask

  task automatic test_ignore_mid_byte();
    int t; int rc; bit to; logic [4:0] got; logic [4:0] e;
    clear_queues();
    send_byte(8'h5A, t);
    repeat (3) step();
    bus.iData = 8'hFF; bus.iData_Ready = 1'b1;
    repeat (3) step();
    bus.iData_Ready = 1'b0; bus.iData = 8'h00;
    step();
    bus.iData = 8'hC3; bus.iData_Ready = 1'b1;
    step();
    bus.iData_Ready = 1'b0;
    wait_ready(100, rc, to);
    checks++; if (to !== 1'b0 || rc - t !== 22) begin errors++; $display("FAIL ignore_ready_return got %0d exp 22", rc - t); end
    repeat (6) step();
    checks++; if (bus.oReadyForData !== 1'b1) begin errors++; $display("FAIL ignore_idle_ready got %b exp 1", bus.oReadyForData); end
    exp_q.push_back(5'h15); exp_q.push_back(5'h1A);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      got = (obs_q.size() > 0) ? obs_q.pop_front() : 5'bx;
      checks++; if (got !== e) begin errors++; $display("FAIL ignore_nibble got %h exp %h", got, e); end
    end
    checks++; if (obs_q.size() !== 0) begin errors++; $display("FAIL ignore_extra got %0d exp 0", obs_q.size()); end
  endtask

  task automatic test_reset_mid_pulse();
    int t; int rc; bit to; bit seenE; logic [4:0] got; logic [4:0] e; int w; int lastFall;
    clear_queues();
    send_byte(8'h33, t);
    seenE = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.oLCD_Enabled === 1'b1) begin seenE = 1'b1; break; end
      step();
    end
    checks++; if (seenE !== 1'b1) begin errors++; $display("FAIL rstpulse_no_E got 0 exp 1"); end
    rst = 1'b1;
    step();
    checks++; if (bus.oLCD_Enabled !== 1'b0) begin errors++; $display("FAIL rstpulse_E_drop got %b exp 0", bus.oLCD_Enabled); end
    checks++; if (bus.oLCD_Data !== 4'h0 || bus.oLCD_RegisterSelect !== 1'b0) begin errors++; $display("FAIL rstpulse_bus got %b/%h exp 0/0", bus.oLCD_RegisterSelect, bus.oLCD_Data); end
    clear_queues();
    repeat (4) step();
    rst = 1'b0;
    collect_init(1'b1, rc, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL rstpulse_init_timeout got timeout exp ready"); end
    lastFall = (fall_q.size() >= 12) ? fall_q[11] : -100;
    checks++; if (rc - lastFall !== 9) begin errors++; $display("FAIL rstpulse_ready_gap got %0d exp 9", rc - lastFall); end
    while (pw_q.size() > 0) begin
      w = pw_q.pop_front();
      checks++; if (w !== 4) begin errors++; $display("FAIL rstpulse_pulse_width got %0d exp 4", w); end
    end
    for (int i = 0; i < 12; i++) exp_q.push_back(initExp[i]);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      got = (obs_q.size() > 0) ? obs_q.pop_front() : 5'bx;
      checks++; if (got !== e) begin errors++; $display("FAIL rstpulse_nibble got %h exp %h", got, e); end
    end
    checks++; if (obs_q.size() !== 0) begin errors++; $display("FAIL rstpulse_extra got %0d exp 0", obs_q.size()); end
  endtask

  task automatic test_invariants();
    checks++; if (invErr !== 0) begin errors++; $display("FAIL bus_invariants got %0d violations exp 0", invErr); end
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_ignore_mid_byte();
    test_reset_mid_pulse();
    test_invariants();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
